// File: rtl/pwm_deadtime_if.sv
// Handshake bundle between the PWM core side and the dead-time stage.
// PWM_DEADTIME_FAULT_EN adds the fault latch signals.
interface pwm_deadtime_if #(
  parameter int DT_WIDTH = 16
);
  logic                enable;
  logic                pwm_in;
  logic [DT_WIDTH-1:0] dead_time;
  logic                pwm_h;
  logic                pwm_l;
  logic                in_dead;
`ifdef PWM_DEADTIME_FAULT_EN
  logic                fault_in;
  logic                fault_clr;
  logic                fault_latched;

  modport master (
    output enable, pwm_in, dead_time,
    output fault_in, fault_clr,
    input  pwm_h, pwm_l, in_dead,
    input  fault_latched
  );

  modport slave (
    input  enable, pwm_in, dead_time,
    input  fault_in, fault_clr,
    output pwm_h, pwm_l, in_dead,
    output fault_latched
  );
`else
  modport master (
    output enable, pwm_in, dead_time,
    input  pwm_h, pwm_l, in_dead
  );

  modport slave (
    input  enable, pwm_in, dead_time,
    output pwm_h, pwm_l, in_dead
  );
`endif
endinterface

// File: rtl/pwm_deadtime.sv
// Complementary gate driver with programmable dead time.
// Optional fault latch enabled by PWM_DEADTIME_FAULT_EN.
module pwm_deadtime #(
  parameter int DT_WIDTH     = 16,
  parameter int H_ACTIVE_LOW = 0,
  parameter int L_ACTIVE_LOW = 0
) (
  input logic          clk,
  input logic          reset,
  pwm_deadtime_if.slave bus
);

  localparam logic H_INV = (H_ACTIVE_LOW != 0);
  localparam logic L_INV = (L_ACTIVE_LOW != 0);

  typedef enum logic [2:0] {
    S_OFF,
    S_DEAD,
    S_H_ON,
`ifdef PWM_DEADTIME_FAULT_EN
    S_L_ON,
    S_FAULT
`else
    S_L_ON
`endif
  } state_t;

  state_t              state;
  state_t              nxt;
  logic                pwm_q;
  logic                tgt;
  logic                nxt_tgt;
  logic [DT_WIDTH-1:0] cnt;
  logic [DT_WIDTH-1:0] nxt_cnt;
  logic                h_q;
  logic                l_q;
  logic                dead_q;
`ifdef PWM_DEADTIME_FAULT_EN
  logic                fault_q;
`endif

  always_comb begin
    nxt     = state;
    nxt_tgt = tgt;
    nxt_cnt = cnt;
`ifdef PWM_DEADTIME_FAULT_EN
    if (bus.fault_in) begin
      nxt = S_FAULT;
    end else if (state == S_FAULT) begin
      if (bus.fault_clr) nxt = S_OFF;
    end else
`endif
    if (!bus.enable) begin
      nxt = S_OFF;
    end else begin
      unique case (state)
        S_OFF: begin
          nxt     = S_DEAD;
          nxt_tgt = pwm_q;
          nxt_cnt = bus.dead_time;
        end
        S_H_ON: begin
          if (!pwm_q) begin
            nxt     = S_DEAD;
            nxt_tgt = 1'b0;
            nxt_cnt = bus.dead_time;
          end
        end
        S_L_ON: begin
          if (pwm_q) begin
            nxt     = S_DEAD;
            nxt_tgt = 1'b1;
            nxt_cnt = bus.dead_time;
          end
        end
        S_DEAD: begin
          // A glitch shorter than the gap just restarts the gap
          if (pwm_q != tgt) begin
            nxt_tgt = pwm_q;
            nxt_cnt = bus.dead_time;
          end else if (cnt == '0) begin
            nxt = tgt ? S_H_ON : S_L_ON;
          end else begin
            nxt_cnt = cnt - DT_WIDTH'(1);
          end
        end
        default: nxt = S_OFF;
      endcase
    end
  end

  // Outputs registered from the next state so they track the state flop
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_OFF;
      pwm_q   <= 1'b0;
      tgt     <= 1'b0;
      cnt     <= '0;
      h_q     <= H_INV;
      l_q     <= L_INV;
      dead_q  <= 1'b0;
`ifdef PWM_DEADTIME_FAULT_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state   <= nxt;
      pwm_q   <= bus.pwm_in;
      tgt     <= nxt_tgt;
      cnt     <= nxt_cnt;
      h_q     <= (nxt == S_H_ON) ^ H_INV;
      l_q     <= (nxt == S_L_ON) ^ L_INV;
      dead_q  <= (nxt == S_DEAD);
`ifdef PWM_DEADTIME_FAULT_EN
      fault_q <= (nxt == S_FAULT);
`endif
    end
  end

  assign bus.pwm_h   = h_q;
  assign bus.pwm_l   = l_q;
  assign bus.in_dead = dead_q;
`ifdef PWM_DEADTIME_FAULT_EN
  assign bus.fault_latched = fault_q;
`endif

endmodule

// File: tb/tb_pwm_deadtime.sv
// Scoreboard bench for pwm_deadtime.
// Expected {pwm_h, pwm_l, in_dead, fault_latched} queued per cycle.
module tb_pwm_deadtime;

  localparam logic [3:0] OFF = 4'b0000;
  localparam logic [3:0] DED = 4'b0010;
  localparam logic [3:0] HON = 4'b1000;
  localparam logic [3:0] LON = 4'b0100;
  localparam logic [3:0] FLT = 4'b0001;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [3:0] sb[$];

  always #5 clk = ~clk;

  pwm_deadtime_if #(.DT_WIDTH(16)) bus ();

  pwm_deadtime #(
    .DT_WIDTH(16),
    .H_ACTIVE_LOW(0),
    .L_ACTIVE_LOW(0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] obs();
`ifdef PWM_DEADTIME_FAULT_EN
    return {bus.pwm_h, bus.pwm_l, bus.in_dead, bus.fault_latched};
`else
    return {bus.pwm_h, bus.pwm_l, bus.in_dead, 1'b0};
`endif
  endfunction

  task automatic test_reset();
    logic [3:0] e, o;
    reset = 1'b1;
    bus.enable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 5) reset = 1'b0;
      bus.pwm_in = i[0];
      sb.push_back(OFF);
      cyc();
      e = sb.pop_front();
      o = obs();
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset cyc %0d: hldf=%b expected %b", i, o, e);
      end
    end
  endtask

  task automatic test_startup();
    logic [3:0] e, o;
    bus.dead_time = 16'd3;
    bus.pwm_in = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i == 2) bus.enable = 1'b1;
      sb.push_back(i < 2 ? OFF : (i < 6 ? DED : HON));
      cyc();
      e = sb.pop_front();
      o = obs();
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL startup cyc %0d: hldf=%b expected %b", i, o, e);
      end
    end
  endtask

  task automatic test_square();
    logic [3:0] e, o;
    logic x, d1, d2;
    bus.dead_time = 16'd0;
    d1 = 1'b1;
    d2 = 1'b1;
    for (int k = 0; k < 200; k++) begin
      x = ((k % 20) < 10);
      bus.pwm_in = x;
      sb.push_back((d1 == d2) ? (d1 ? HON : LON) : DED);
      cyc();
      e = sb.pop_front();
      o = obs();
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL square cyc %0d: hldf=%b expected %b", k, o, e);
      end
      n_chk++;
      if ((bus.pwm_h & bus.pwm_l) !== 1'b0) begin
        n_fail++;
        $display("FAIL overlap cyc %0d: h=%b l=%b required not both 1",
                 k, bus.pwm_h, bus.pwm_l);
      end
      d2 = d1;
      d1 = x;
    end
  endtask

  task automatic test_retarget();
    logic [3:0] e, o;
    bus.dead_time = 16'd5;
    bus.pwm_in = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (i == 2) bus.dead_time = 16'd9;
      if (i == 8) bus.dead_time = 16'd5;
      sb.push_back(i == 0 ? LON : (i < 7 ? DED : HON));
      cyc();
      e = sb.pop_front();
      o = obs();
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL dt_latch cyc %0d: hldf=%b expected %b", i, o, e);
      end
    end
    for (int j = 0; j < 12; j++) begin
      bus.pwm_in = (j >= 2);
      sb.push_back(j == 0 ? HON : (j < 9 ? DED : HON));
      cyc();
      e = sb.pop_front();
      o = obs();
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL retarget cyc %0d: hldf=%b expected %b", j, o, e);
      end
    end
  endtask

  task automatic test_enable_reset();
    logic [3:0] e, o;
    logic [3:0] exp_t[13];
    exp_t = '{OFF, OFF, OFF, DED, DED, DED, HON, HON,
              OFF, DED, DED, OFF, OFF};
    for (int i = 0; i < 13; i++) begin
      reset = 1'b0;
      unique case (1'b1)
        (i == 0):  bus.enable = 1'b0;
        (i == 3): begin
          bus.dead_time = 16'd2;
          bus.enable = 1'b1;
        end
        (i == 8):  bus.enable = 1'b0;
        (i == 9):  bus.enable = 1'b1;
        (i == 11): begin
          reset = 1'b1;
          bus.enable = 1'b0;
        end
        default: ;
      endcase
      sb.push_back(exp_t[i]);
      cyc();
      e = sb.pop_front();
      o = obs();
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL enable_reset cyc %0d: hldf=%b expected %b", i, o, e);
      end
    end
    reset = 1'b0;
  endtask

`ifdef PWM_DEADTIME_FAULT_EN
  task automatic test_fault();
    logic [3:0] e, o;
    logic [3:0] exp_t[14];
    exp_t = '{OFF, OFF, DED, DED, LON, LON, FLT, FLT,
              FLT, FLT, OFF, DED, DED, LON};
    bus.pwm_in = 1'b0;
    bus.enable = 1'b0;
    bus.dead_time = 16'd1;
    for (int i = 0; i < 14; i++) begin
      bus.enable = (i >= 2);
      bus.fault_in = (i == 6);
      bus.fault_clr = (i == 10);
      sb.push_back(exp_t[i]);
      cyc();
      e = sb.pop_front();
      o = obs();
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL fault cyc %0d: hldf=%b expected %b", i, o, e);
      end
    end
    bus.fault_clr = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b1;
    bus.enable = 1'b0;
    bus.pwm_in = 1'b0;
    bus.dead_time = '0;
`ifdef PWM_DEADTIME_FAULT_EN
    bus.fault_in = 1'b0;
    bus.fault_clr = 1'b0;
`endif
    test_reset();
    test_startup();
    test_square();
    test_retarget();
    test_enable_reset();
`ifdef PWM_DEADTIME_FAULT_EN
    test_fault();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
